// File: rtl/cachebusarb_pkg.sv
// Shared types and constants for the cache-line bus arbiter.
package cvw;

    // Arbiter states: idle, D$ owns the bus, I$ owns the bus, line acknowledge
    typedef enum logic [1:0] {ARB_IDLE, ARB_DOWN, ARB_IOWN, ARB_ACK} arbstate_t;

    // Which cache owns (or last owned) the line transaction
    typedef enum logic {OWNER_I = 1'b0, OWNER_D = 1'b1} owner_t;

    // log2 of the cache line size in bytes (64-byte lines)
    localparam int OFFSET = 6;

    // Bus request encodings
    localparam logic [1:0] RW_NONE      = 2'b00;
    localparam logic [1:0] RW_WRITEBACK = 2'b01;
    localparam logic [1:0] RW_FETCH     = 2'b10;

endpackage

// File: rtl/cachebusarb_beatcounter.sv
// Small storage primitives used by the arbiter: an enabled flop with
// async active-low reset, and a wrapping beat counter.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture d when enabled; clear on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  q <= '0;
        else if (en) q <= d;
    end

endmodule

module beatcounter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count beats, wrapping naturally to zero; clear has priority over count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      count <= '0;
        else if (clear)  count <= '0;
        else if (en)     count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/cachebusarb.sv
// Two-requester line-burst arbiter sharing one cache bus between I$ and D$.
// One cache is granted per line; beats are counted and the line-complete
// acknowledge is returned only to the owner.
module cachebusarb
    import cvw::*;
#(
    parameter int PA_BITS      = 34,
    parameter int BEATSPERLINE = 8,
    parameter int LOGBWPL      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         DCacheBusRW,
    input  logic [PA_BITS-1:0] DCacheBusAdr,
    input  logic [1:0]         ICacheBusRW,
    input  logic [PA_BITS-1:0] ICacheBusAdr,
    input  logic               BusBeatDone,
    output logic [1:0]         BusRW,
    output logic [PA_BITS-1:0] BusAdr,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic               DSelBusBeat,
    output logic               ISelBusBeat,
    output logic               DCacheBusAck,
    output logic               ICacheBusAck
);

    // Upper line-address bits kept, and byte-within-beat bits forced to zero
    localparam int ADR_HI_BITS = PA_BITS - OFFSET;
    localparam int BYTE_BITS   = OFFSET - LOGBWPL;

    arbstate_t              state, nextState;
    owner_t                 owner, lastGrant;
    logic                   dWbPend;
    logic                   dReq, iReq;
    logic                   grant, grantD;
    logic                   owned, lastBeat;
    logic [1:0]             grantRW, latchedRW;
    logic [ADR_HI_BITS-1:0] grantAdr, latchedAdr;
    logic                   unusedBits;

    // I$ writeback bit and sub-line address bits play no part in arbitration
    assign unusedBits = ^{ICacheBusRW[0], DCacheBusAdr[OFFSET-1:0], ICacheBusAdr[OFFSET-1:0]};

    assign dReq     = |DCacheBusRW;
    assign iReq     = ICacheBusRW[1];
    assign owned    = (state == ARB_DOWN) || (state == ARB_IOWN);
    assign lastBeat = BusBeatDone && (BeatCount == LOGBWPL'(BEATSPERLINE - 1));

    // Request and address of the winner; a D$ writeback beats a fetch
    assign grantRW  = (grantD && DCacheBusRW[0]) ? RW_WRITEBACK : RW_FETCH;
    assign grantAdr = grantD ? DCacheBusAdr[PA_BITS-1:OFFSET] : ICacheBusAdr[PA_BITS-1:OFFSET];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= nextState;
    end

    // Arbitration and burst sequencing; a pending D$ writeback keeps D$ first
    always_comb begin
        nextState = state;
        grant     = 1'b0;
        grantD    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dReq || iReq) begin
                    grant     = 1'b1;
                    grantD    = dReq && (!iReq || dWbPend || (lastGrant == OWNER_I));
                    nextState = grantD ? ARB_DOWN : ARB_IOWN;
                end
            end
            ARB_DOWN, ARB_IOWN: begin
                if (lastBeat) nextState = ARB_ACK;
            end
            ARB_ACK:  nextState = ARB_IDLE;
            default:  nextState = ARB_IDLE;
        endcase
    end

    // Owner, fairness history and writeback-pending flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWNER_I;
            lastGrant <= OWNER_I;
            dWbPend   <= 1'b0;
        end else begin
            if (grant) owner <= grantD ? OWNER_D : OWNER_I;
            if (state == ARB_ACK) begin
                lastGrant <= owner;
                dWbPend   <= (owner == OWNER_D) && (latchedRW == RW_WRITEBACK);
            end
        end
    end

    flopenr #(.WIDTH(2)) rwReg (
        .clk   (clk),
        .reset (reset),
        .en    (grant),
        .d     (grantRW),
        .q     (latchedRW)
    );

    flopenr #(.WIDTH(ADR_HI_BITS)) adrReg (
        .clk   (clk),
        .reset (reset),
        .en    (grant),
        .d     (grantAdr),
        .q     (latchedAdr)
    );

    beatcounter #(.WIDTH(LOGBWPL)) beatCounter (
        .clk   (clk),
        .reset (reset),
        .clear (grant),
        .en    (owned && BusBeatDone),
        .count (BeatCount)
    );

    assign DSelBusBeat  = (state == ARB_DOWN);
    assign ISelBusBeat  = (state == ARB_IOWN);
    assign BusRW        = owned ? latchedRW : RW_NONE;
    assign BusAdr       = owned ? {latchedAdr, BeatCount, {BYTE_BITS{1'b0}}} : '0;
    assign DCacheBusAck = (state == ARB_ACK) && (owner == OWNER_D);
    assign ICacheBusAck = (state == ARB_ACK) && (owner == OWNER_I);

    // A beat completion is only meaningful while a cache owns the bus
    assert property (@(posedge clk) disable iff (!reset) BusBeatDone |-> owned);

endmodule

// File: tb/tb_cachebusarb.sv
// Directed self-checking bench for the cache bus arbiter.
module tb_cachebusarb;

    localparam int PA_BITS      = 34;
    localparam int BEATSPERLINE = 8;
    localparam int LOGBWPL      = 3;

    logic               clk = 1'b0;
    logic               rstN = 1'b1;
    logic [1:0]         dRW, iRW;
    logic [PA_BITS-1:0] dAdr, iAdr;
    logic               beatDone;
    logic [1:0]         busRW;
    logic [PA_BITS-1:0] busAdr;
    logic [LOGBWPL-1:0] beatCount;
    logic               dSel, iSel, dAck, iAck;
    logic [PA_BITS-1:0] expAdr;

    int compared   = 0;
    int mismatched = 0;

    cachebusarb #(
        .PA_BITS      (PA_BITS),
        .BEATSPERLINE (BEATSPERLINE),
        .LOGBWPL      (LOGBWPL)
    ) dut (
        .clk          (clk),
        .reset        (rstN),
        .DCacheBusRW  (dRW),
        .DCacheBusAdr (dAdr),
        .ICacheBusRW  (iRW),
        .ICacheBusAdr (iAdr),
        .BusBeatDone  (beatDone),
        .BusRW        (busRW),
        .BusAdr       (busAdr),
        .BeatCount    (beatCount),
        .DSelBusBeat  (dSel),
        .ISelBusBeat  (iSel),
        .DCacheBusAck (dAck),
        .ICacheBusAck (iAck)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [1:0] dr, input logic [PA_BITS-1:0] da,
                                 input logic [1:0] ir, input logic [PA_BITS-1:0] ia);
        dRW  = dr;
        dAdr = da;
        iRW  = ir;
        iAdr = ia;
    endtask

    // Pulse BusBeatDone for n consecutive cycles, ending on a falling edge
    task automatic driveBeats(input int n);
        for (int i = 0; i < n; i++) begin
            beatDone = 1'b1;
            @(negedge clk);
        end
        beatDone = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(2'b00, '0, 2'b00, '0);
        beatDone = 1'b0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        applyStimulus(2'b00, '0, 2'b00, '0);
        beatDone = 1'b0;
        rstN = 1'b1;
        #2 rstN = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (busRW !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_rw: got %b expected 00", busRW); end
        compared++; if (busAdr !== '0) begin mismatched++; $display("[TB] FAIL reset_adr: got %h expected 0", busAdr); end
        compared++; if (beatCount !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d expected 0", beatCount); end
        compared++; if ({dSel, iSel, dAck, iAck} !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 0000", {dSel, iSel, dAck, iAck}); end
        rstN = 1'b1;
        @(negedge clk);
        compared++; if ({dSel, iSel} !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_idle: got %b expected 00", {dSel, iSel}); end
    endtask

    task automatic test_dfetch();
        applyStimulus(2'b10, 34'h0_8000_0040, 2'b00, '0);
        @(negedge clk);
        compared++; if (busRW !== 2'b10) begin mismatched++; $display("[TB] FAIL dfetch_rw: got %b expected 10", busRW); end
        compared++; if ({dSel, iSel} !== 2'b10) begin mismatched++; $display("[TB] FAIL dfetch_sel: got %b expected 10", {dSel, iSel}); end
        for (int b = 0; b < BEATSPERLINE; b++) begin
            expAdr = 34'h0_8000_0040 + 34'(8 * b);
            compared++; if (busAdr !== expAdr) begin mismatched++; $display("[TB] FAIL dfetch_adr%0d: got %h expected %h", b, busAdr, expAdr); end
            compared++; if (beatCount !== 3'(b)) begin mismatched++; $display("[TB] FAIL dfetch_count%0d: got %0d expected %0d", b, beatCount, b); end
            compared++; if ({dAck, iAck} !== 2'b00) begin mismatched++; $display("[TB] FAIL dfetch_earlyack%0d: got %b expected 00", b, {dAck, iAck}); end
            beatDone = 1'b1;
            @(negedge clk);
        end
        beatDone = 1'b0;
        compared++; if ({dAck, iAck} !== 2'b10) begin mismatched++; $display("[TB] FAIL dfetch_ack: got %b expected 10", {dAck, iAck}); end
        compared++; if (busRW !== 2'b00) begin mismatched++; $display("[TB] FAIL dfetch_ackrw: got %b expected 00", busRW); end
        applyStimulus(2'b00, '0, 2'b00, '0);
        @(negedge clk);
        compared++; if ({dSel, iSel, dAck, iAck} !== 4'b0000) begin mismatched++; $display("[TB] FAIL dfetch_done: got %b expected 0000", {dSel, iSel, dAck, iAck}); end
    endtask

    task automatic test_simultaneous();
        applyStimulus(2'b10, 34'h0_8000_0200, 2'b10, 34'h1_2345_67C5);
        @(negedge clk);
        compared++; if ({dSel, iSel} !== 2'b10) begin mismatched++; $display("[TB] FAIL sim_firstgrant: got %b expected 10", {dSel, iSel}); end
        compared++; if (busAdr !== 34'h0_8000_0200) begin mismatched++; $display("[TB] FAIL sim_dadr: got %h expected 080000200", busAdr); end
        driveBeats(8);
        compared++; if ({dAck, iAck} !== 2'b10) begin mismatched++; $display("[TB] FAIL sim_dack: got %b expected 10", {dAck, iAck}); end
        applyStimulus(2'b00, '0, 2'b10, 34'h1_2345_67C5);
        @(negedge clk);
        compared++; if ({dSel, iSel, busRW} !== 4'b0000) begin mismatched++; $display("[TB] FAIL sim_idle: got %b expected 0000", {dSel, iSel, busRW}); end
        @(negedge clk);
        compared++; if ({dSel, iSel} !== 2'b01) begin mismatched++; $display("[TB] FAIL sim_igrant: got %b expected 01", {dSel, iSel}); end
        compared++; if (busAdr !== 34'h1_2345_67C0) begin mismatched++; $display("[TB] FAIL sim_iadr: got %h expected 1234567c0", busAdr); end
        driveBeats(7);
        compared++; if (busAdr !== 34'h1_2345_67F8) begin mismatched++; $display("[TB] FAIL sim_iadr7: got %h expected 1234567f8", busAdr); end
        driveBeats(1);
        compared++; if ({dAck, iAck} !== 2'b01) begin mismatched++; $display("[TB] FAIL sim_iack: got %b expected 01", {dAck, iAck}); end
        applyStimulus(2'b00, '0, 2'b00, '0);
        @(negedge clk);
    endtask

    task automatic test_wb_then_fetch();
        applyStimulus(2'b01, 34'h0_8000_0400, 2'b10, 34'h0_8000_1000);
        @(negedge clk);
        compared++; if ({dSel, iSel} !== 2'b10) begin mismatched++; $display("[TB] FAIL wb_grant: got %b expected 10", {dSel, iSel}); end
        compared++; if (busRW !== 2'b01) begin mismatched++; $display("[TB] FAIL wb_rw: got %b expected 01", busRW); end
        driveBeats(8);
        compared++; if ({dAck, iAck} !== 2'b10) begin mismatched++; $display("[TB] FAIL wb_ack: got %b expected 10", {dAck, iAck}); end
        applyStimulus(2'b10, 34'h0_8000_0800, 2'b10, 34'h0_8000_1000);
        @(negedge clk);
        @(negedge clk);
        compared++; if ({dSel, iSel} !== 2'b10) begin mismatched++; $display("[TB] FAIL wb_pendgrant: got %b expected 10", {dSel, iSel}); end
        compared++; if (busRW !== 2'b10) begin mismatched++; $display("[TB] FAIL wb_fetchrw: got %b expected 10", busRW); end
        compared++; if (busAdr !== 34'h0_8000_0800) begin mismatched++; $display("[TB] FAIL wb_fetchadr: got %h expected 080000800", busAdr); end
        driveBeats(8);
        compared++; if ({dAck, iAck} !== 2'b10) begin mismatched++; $display("[TB] FAIL wb_fetchack: got %b expected 10", {dAck, iAck}); end
        applyStimulus(2'b00, '0, 2'b10, 34'h0_8000_1000);
        @(negedge clk);
        @(negedge clk);
        compared++; if ({dSel, iSel} !== 2'b01) begin mismatched++; $display("[TB] FAIL wb_thirdgrant: got %b expected 01", {dSel, iSel}); end
        compared++; if (busAdr !== 34'h0_8000_1000) begin mismatched++; $display("[TB] FAIL wb_iadr: got %h expected 080001000", busAdr); end
        driveBeats(8);
        compared++; if ({dAck, iAck} !== 2'b01) begin mismatched++; $display("[TB] FAIL wb_iack: got %b expected 01", {dAck, iAck}); end
        applyStimulus(2'b00, '0, 2'b00, '0);
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic expD;
        applyStimulus(2'b10, 34'h0_8000_2000, 2'b10, 34'h0_8000_3000);
        @(negedge clk);
        for (int line = 0; line < 4; line++) begin
            expD = ((line % 2) == 0);
            expAdr = expD ? 34'h0_8000_2000 : 34'h0_8000_3000;
            compared++; if ({dSel, iSel} !== {expD, ~expD}) begin mismatched++; $display("[TB] FAIL cont_grant%0d: got %b expected %b", line, {dSel, iSel}, {expD, ~expD}); end
            compared++; if (busAdr !== expAdr) begin mismatched++; $display("[TB] FAIL cont_adr%0d: got %h expected %h", line, busAdr, expAdr); end
            driveBeats(8);
            compared++; if ({dAck, iAck} !== {expD, ~expD}) begin mismatched++; $display("[TB] FAIL cont_ack%0d: got %b expected %b", line, {dAck, iAck}, {expD, ~expD}); end
            if (line < 3) begin
                @(negedge clk);
                @(negedge clk);
            end
        end
        applyStimulus(2'b00, '0, 2'b00, '0);
        @(negedge clk);
    endtask

    task automatic test_reset_midburst();
        applyStimulus(2'b11, 34'h0_8000_5000, 2'b00, '0);
        @(negedge clk);
        compared++; if (busRW !== 2'b01) begin mismatched++; $display("[TB] FAIL mid_rw11: got %b expected 01", busRW); end
        driveBeats(3);
        compared++; if (beatCount !== 3'd3) begin mismatched++; $display("[TB] FAIL mid_count3: got %0d expected 3", beatCount); end
        rstN = 1'b0;
        applyStimulus(2'b00, '0, 2'b00, '0);
        #1;
        compared++; if ({busRW, beatCount} !== 5'b0) begin mismatched++; $display("[TB] FAIL mid_rwcount: got %b expected 00000", {busRW, beatCount}); end
        compared++; if (busAdr !== '0) begin mismatched++; $display("[TB] FAIL mid_adr: got %h expected 0", busAdr); end
        compared++; if ({dSel, iSel, dAck, iAck} !== 4'b0000) begin mismatched++; $display("[TB] FAIL mid_flags: got %b expected 0000", {dSel, iSel, dAck, iAck}); end
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        compared++; if ({dAck, iAck} !== 2'b00) begin mismatched++; $display("[TB] FAIL mid_noack: got %b expected 00", {dAck, iAck}); end
        applyStimulus(2'b10, 34'h0_8000_6000, 2'b00, '0);
        @(negedge clk);
        compared++; if (beatCount !== 3'd0) begin mismatched++; $display("[TB] FAIL mid_restart: got %0d expected 0", beatCount); end
        compared++; if (busAdr !== 34'h0_8000_6000) begin mismatched++; $display("[TB] FAIL mid_newadr: got %h expected 080006000", busAdr); end
        driveBeats(8);
        compared++; if ({dAck, iAck} !== 2'b10) begin mismatched++; $display("[TB] FAIL mid_newack: got %b expected 10", {dAck, iAck}); end
        applyStimulus(2'b00, '0, 2'b00, '0);
        @(negedge clk);
    endtask

    task automatic test_idrop();
        applyStimulus(2'b00, '0, 2'b01, 34'h0_8000_7000);
        @(negedge clk);
        compared++; if ({dSel, iSel} !== 2'b00) begin mismatched++; $display("[TB] FAIL idrop_ignore01: got %b expected 00", {dSel, iSel}); end
        applyStimulus(2'b00, '0, 2'b11, 34'h0_8000_7000);
        @(negedge clk);
        compared++; if ({dSel, iSel, busRW} !== 4'b0110) begin mismatched++; $display("[TB] FAIL idrop_grant: got %b expected 0110", {dSel, iSel, busRW}); end
        driveBeats(3);
        applyStimulus(2'b00, '0, 2'b00, '0);
        driveBeats(4);
        compared++; if ({iSel, busRW, beatCount} !== 6'b110111) begin mismatched++; $display("[TB] FAIL idrop_held: got %b expected 110111", {iSel, busRW, beatCount}); end
        driveBeats(1);
        compared++; if ({dAck, iAck} !== 2'b01) begin mismatched++; $display("[TB] FAIL idrop_ack: got %b expected 01", {dAck, iAck}); end
        @(negedge clk);
        compared++; if ({dSel, iSel, dAck, iAck} !== 4'b0000) begin mismatched++; $display("[TB] FAIL idrop_onepulse: got %b expected 0000", {dSel, iSel, dAck, iAck}); end
        @(negedge clk);
        compared++; if ({dSel, iSel, dAck, iAck} !== 4'b0000) begin mismatched++; $display("[TB] FAIL idrop_nogrant: got %b expected 0000", {dSel, iSel, dAck, iAck}); end
    endtask

    initial begin
        beatDone = 1'b0;
        applyStimulus(2'b00, '0, 2'b00, '0);
        test_reset();
        test_dfetch();
        doReset();
        test_simultaneous();
        doReset();
        test_wb_then_fetch();
        test_contention();
        test_reset_midburst();
        test_idrop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
